muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file: it captures the two source operands read from the register file, computes one of the eight M-extension operations over multiple cycles, and returns a result with its destination register address for write-back into the register file's write port. The pipeline stalls on `BUSY`, and a flush aborts an operation in flight.

## Interface
- `WIDTH`, 32, operand/result width
- `ADD_WIDTH`, 5, register address width
- `CLK` in 1: clock, all state on rising edge
- `RESET` in 1: asynchronous, active-low reset
- `START` in 1: issue request; accepted only when `BUSY`=0
- `OP` in 3: funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `OPERAND_A` in WIDTH: rs1 value (register file read port 1)
- `OPERAND_B` in WIDTH: rs2 value (register file read port 2)
- `RD_ADDR` in ADD_WIDTH: destination register
- `KILL` in 1: synchronous abort of the operation in flight
- `BUSY` out 1: unit occupied (CALC or DONE state)
- `WB_VALID` out 1: one-cycle result strobe, drives register file write enable
- `WB_ADDR` out ADD_WIDTH: destination, held from issue
- `WB_DATA` out WIDTH: result

## Operation
- States: IDLE, CALC, DONE. Reset is asynchronous and active-low. Reset forces IDLE, counter 0, and all outputs 0: `BUSY`, `WB_VALID`, `WB_ADDR`, `WB_DATA`.
- IDLE: on `START`, latch `OP`, the operands and `RD_ADDR`.
  - Special cases go straight to DONE:
    - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = `OPERAND_A`.
    - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
  - All other operations go to CALC with counter = 0.
- CALC:
  - Signed operands are first converted to magnitudes:
    - MULH, DIV and REM: both operands.
    - MULHSU: `OPERAND_A` only.
  - One iteration per cycle, 32 iterations:
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
  - After iteration 31, apply the sign fix and go to DONE:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
- Result selection:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
- DONE: `WB_VALID`=1 for exactly one cycle with `WB_DATA`/`WB_ADDR`; the unit then returns to IDLE.
- `RD_ADDR`=0: the unit computes and strobes normally; the register file discards the write.
- `KILL`:
  - In CALC or DONE: return to IDLE next edge; `WB_VALID` is forced 0 in that cycle.
  - In IDLE it has priority over `START` (request dropped).
- `START` while `BUSY`=1 is ignored. `OP`/operand changes after issue have no effect.

## Timing
- Issue in cycle 0 (`START`=1, `BUSY`=0). `BUSY`=1 from cycle 1 until the end of DONE.
- Normal operation: CALC in cycles 1–32, DONE/`WB_VALID` in cycle 33. The next issue is accepted in cycle 34.
- Special case: DONE in cycle 1; next issue in cycle 2.
- `WB_*` are registered outputs; no combinational path from inputs to outputs.
- `RESET` assertion mid-CALC clears state immediately; no `WB_VALID` is produced for the lost operation.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier and go IDLE→DONE, with `WB_VALID` in cycle 1.
  - Divide operations are unchanged.
- Undefined: multiplication is iterative (33-cycle latency); no multiplier is inferred.

## Structure
- Shared package `muldiv_pkg` holds:
  - OP funct3 localparams (`OP_MUL` … `OP_REMU`).
  - State encoding (IDLE/CALC/DONE).
  - The iteration count constant (32).
  - Special-case constants (0xFFFFFFFF, 0x80000000).
- Sub-module `muldiv_iter_core` holds the per-cycle datapath: accumulator/remainder registers, the shift-add/subtract step, and the counter, with `step`/`load` controls.
- The top level owns the FSM, operand sign handling, the special-case detect, the sign fix and the write-back registers.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), rd=5 → `WB_VALID` in cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`), `WB_DATA`=0xFFFFFFEB, `WB_ADDR`=5. The same operands under MULHU → 0x00000006.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2, each in cycle 33.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All in cycle 1.
- Back-to-back: `START` held high continuously → issues accepted in cycles 0 and 34 only, exactly two `WB_VALID` pulses by cycle 67.
- `KILL` in cycle 10 of a DIV → `BUSY`=0 in cycle 11, no `WB_VALID`; a new MULHSU 0xFFFFFFFF × 0xFFFFFFFF issued in cycle 11 → 0xFFFFFFFF.
- `RESET` low in cycle 20 of a MUL → all outputs 0 immediately. After release, an issue completes normally with no stale strobe.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states,
// iteration count and the fixed results of the divide special cases.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int ITER_COUNT = 32;

   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue / write-back bundle between the register file side and the multiply/divide unit.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = XLEN,
   parameter int ADD_WIDTH = 5
);
   logic                 START;
   logic [2:0]           OP;
   logic [WIDTH-1:0]     OPERAND_A;
   logic [WIDTH-1:0]     OPERAND_B;
   logic [ADD_WIDTH-1:0] RD_ADDR;
   logic                 KILL;
   logic                 BUSY;
   logic                 WB_VALID;
   logic [ADD_WIDTH-1:0] WB_ADDR;
   logic [WIDTH-1:0]     WB_DATA;

   modport master (
      output START, OP, OPERAND_A, OPERAND_B, RD_ADDR, KILL,
      input  BUSY, WB_VALID, WB_ADDR, WB_DATA
   );

   modport slave (
      input  START, OP, OPERAND_A, OPERAND_B, RD_ADDR, KILL,
      output BUSY, WB_VALID, WB_ADDR, WB_DATA
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply or restoring divide on a
// double-width accumulator, plus the iteration counter.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_i,
   input  logic           step_i,
   input  logic           is_div_i,
   input  logic [W-1:0]   acc_lo_i,
   input  logic [W-1:0]   m_i,
   output logic [2*W-1:0] acc_next_o,
   output logic           last_o
);
   localparam int CNT_W = $clog2(ITER_COUNT);

   logic [2*W-1:0]   acc_q;
   logic [W-1:0]     m_q;
   logic             is_div_q;
   logic [CNT_W-1:0] cnt_q;

   logic [W:0]       mul_sum;
   logic [W:0]       div_shift;
   logic [W:0]       div_trial;
   logic             div_fits;

   // Multiply: low half holds the multiplier, consumed LSB first while the sum shifts in.
   assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);

   // Divide: high half is the partial remainder, low half the dividend turning into the quotient.
   assign div_shift = acc_q[2*W-1:W-1];
   assign div_trial = div_shift - {1'b0, m_q};
   assign div_fits  = (div_shift >= {1'b0, m_q});

   always_comb begin
      acc_next_o = {mul_sum, acc_q[W-1:1]};
      if (is_div_q) begin
         acc_next_o = div_fits ? {div_trial[W-1:0], acc_q[W-2:0], 1'b1}
                               : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
      end
   end

   assign last_o = (cnt_q == CNT_W'(ITER_COUNT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         m_q      <= '0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
      end else if (load_i) begin
         acc_q    <= {{W{1'b0}}, acc_lo_i};
         m_q      <= m_i;
         is_div_q <= is_div_i;
         cnt_q    <= '0;
      end else if (step_i) begin
         acc_q    <= acc_next_o;
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, operand sign handling, special cases and write-back.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = XLEN,
   parameter int ADD_WIDTH = 5
) (
   input logic     CLK,
   input logic     RESET,
   muldiv_if.slave bus
);
   state_t               state_q, state_d;
   logic [2:0]           op_q;
   logic                 neg_res_q, neg_rem_q;
   logic                 wb_valid_q, wb_valid_d;
   logic [ADD_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [WIDTH-1:0]     wb_data_q, wb_data_d;

   logic                 is_div_op, a_neg, b_neg, div_zero, div_ovf, issue;
   logic [WIDTH-1:0]     a_mag, b_mag, special_res, fast_res, calc_res;
   logic                 core_load, core_step, core_last;
   logic [WIDTH-1:0]     core_acc_lo, core_m;
   logic [2*WIDTH-1:0]   core_next, prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign is_div_op   = bus.OP[2];
   assign a_neg       = op_signed_a(bus.OP) & bus.OPERAND_A[WIDTH-1];
   assign b_neg       = op_signed_b(bus.OP) & bus.OPERAND_B[WIDTH-1];
   assign a_mag       = a_neg ? -bus.OPERAND_A : bus.OPERAND_A;
   assign b_mag       = b_neg ? -bus.OPERAND_B : bus.OPERAND_B;
   assign div_zero    = is_div_op && (bus.OPERAND_B == '0);
   assign div_ovf     = ((bus.OP == OP_DIV) || (bus.OP == OP_REM)) &&
                        (bus.OPERAND_A == INT_MIN) && (bus.OPERAND_B == ALL_ONES);
   // OP[1] separates REM/REMU from DIV/DIVU
   assign special_res = div_zero ? (bus.OP[1] ? bus.OPERAND_A : ALL_ONES)
                                 : (bus.OP[1] ? '0 : INT_MIN);
   assign issue       = (state_q == ST_IDLE) && bus.START && !bus.KILL;

   assign core_acc_lo = is_div_op ? a_mag : b_mag;
   assign core_m      = is_div_op ? b_mag : a_mag;

   muldiv_iter_core #(.W(WIDTH)) u_core (
      .clk        (CLK),
      .rst_n      (RESET),
      .load_i     (core_load),
      .step_i     (core_step),
      .is_div_i   (is_div_op),
      .acc_lo_i   (core_acc_lo),
      .m_i        (core_m),
      .acc_next_o (core_next),
      .last_o     (core_last)
   );

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
   logic signed [WIDTH:0]     fast_a, fast_b;
   logic signed [2*WIDTH-1:0] fast_prod;
   assign fast_a    = $signed({a_neg, bus.OPERAND_A});
   assign fast_b    = $signed({b_neg, bus.OPERAND_B});
   assign fast_prod = fast_a * fast_b;
   assign fast_res  = (bus.OP == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
`else
   localparam bit FAST_MUL = 1'b0;
   assign fast_res = '0;
`endif

   // Sign fix applied to the value the last iteration is about to write
   assign prod_fix = neg_res_q ? -core_next : core_next;
   assign quo_fix  = neg_res_q ? -core_next[WIDTH-1:0] : core_next[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -core_next[2*WIDTH-1:WIDTH] : core_next[2*WIDTH-1:WIDTH];

   always_comb begin
      case (op_q)
         OP_MUL:                       calc_res = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              calc_res = quo_fix;
         default:                      calc_res = rem_fix;
      endcase
   end

   // NOTE: defaults first so no path through the case leaves a latch.
   always_comb begin
      state_d    = state_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               wb_addr_d = bus.RD_ADDR;
               if (div_zero || div_ovf) begin
                  state_d    = ST_DONE;
                  wb_valid_d = 1'b1;
                  wb_data_d  = special_res;
               end else if (FAST_MUL && !is_div_op) begin
                  state_d    = ST_DONE;
                  wb_valid_d = 1'b1;
                  wb_data_d  = fast_res;
               end else begin
                  core_load  = 1'b1;
                  state_d    = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (bus.KILL) begin
               state_d = ST_IDLE;
            end else begin
               core_step = 1'b1;
               if (core_last) begin
                  state_d    = ST_DONE;
                  wb_valid_d = 1'b1;
                  wb_data_d  = calc_res;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         op_q       <= OP_MUL;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         if (issue) begin
            op_q      <= bus.OP;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
         end
      end
   end

   assign bus.BUSY     = (state_q != ST_IDLE);
   assign bus.WB_VALID = wb_valid_q;
   assign bus.WB_ADDR  = wb_addr_q;
   assign bus.WB_DATA  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random bench for muldiv_unit, checked against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   muldiv_if #(.WIDTH(32), .ADD_WIDTH(5)) bus ();

   muldiv_unit #(.WIDTH(32), .ADD_WIDTH(5)) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference results straight from the RV32M definitions using 64-bit arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua % ub; return up[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= 3'd4) begin
         if (b == 0) return 1;
         if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return 33;
      end
      return MUL_LAT;
   endfunction

   // Called at a falling edge with the unit idle; that cycle is cycle 0 of the issue.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_lat);
      int cyc;
      bus.START     = 1'b1;
      bus.OP        = op;
      bus.OPERAND_A = a;
      bus.OPERAND_B = b;
      bus.RD_ADDR   = rd;
      bus.KILL      = 1'b0;
      @(negedge clk);
      cyc = 1;
      bus.START     = 1'b0;
      bus.OP        = 3'($urandom);
      bus.OPERAND_A = $urandom;
      bus.OPERAND_B = $urandom;
      bus.RD_ADDR   = 5'($urandom);
      check({tag, "/busy1"}, 64'(bus.BUSY), 64'd1);
      while (bus.WB_VALID !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "/lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, "/data"}, 64'(bus.WB_DATA), 64'(exp_data));
      check({tag, "/addr"}, 64'(bus.WB_ADDR), 64'(rd));
      @(negedge clk);
      check({tag, "/strobe_once"}, 64'(bus.WB_VALID), 64'd0);
      check({tag, "/idle_after"}, 64'(bus.BUSY), 64'd0);
   endtask

   initial begin
      int pulses, first, second, seen;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          sel;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.START = 1'b0; bus.OP = 3'd0; bus.OPERAND_A = '0; bus.OPERAND_B = '0;
      bus.RD_ADDR = '0; bus.KILL = 1'b0;
      repeat (2) @(negedge clk);
      check("rst/busy",  64'(bus.BUSY),     64'd0);
      check("rst/valid", 64'(bus.WB_VALID), 64'd0);
      check("rst/addr",  64'(bus.WB_ADDR),  64'd0);
      check("rst/data",  64'(bus.WB_DATA),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases with hand-computed results
      run_op("mul_7x-3",   OP_MUL,   32'h7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
      run_op("mulhu_7x-3", OP_MULHU, 32'h7,          32'hFFFF_FFFD, 5'd5,  32'h0000_0006, MUL_LAT);
      run_op("div_-7/2",   OP_DIV,   32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 33);
      run_op("rem_-7/2",   OP_REM,   32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 33);
      run_op("divu_100/7", OP_DIVU,  32'd100,        32'd7,         5'd8,  32'd14,        33);
      run_op("remu_100/7", OP_REMU,  32'd100,        32'd7,         5'd9,  32'd2,         33);
      run_op("div_5/0",    OP_DIV,   32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1);
      run_op("rem_5/0",    OP_REM,   32'd5,          32'd0,         5'd11, 32'd5,         1);
      run_op("div_ovf",    OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
      run_op("rem_ovf",    OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h0,         1);
      run_op("rd0",        OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd0,  32'h0,         MUL_LAT);

      // START held high: issues only at cycles 0 and 34
      pulses = 0; first = -1; second = -1;
      bus.START = 1'b1; bus.OP = OP_DIVU; bus.OPERAND_A = 32'd100; bus.OPERAND_B = 32'd7;
      bus.RD_ADDR = 5'd3;
      for (int c = 1; c <= 67; c++) begin
         @(negedge clk);
         if (bus.WB_VALID === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
            else second = c;
         end
      end
      bus.START = 1'b0;
      check("b2b/pulses", 64'(pulses), 64'd2);
      check("b2b/first",  64'(first),  64'd33);
      check("b2b/second", 64'(second), 64'd67);
      @(negedge clk);
      check("b2b/idle", 64'(bus.BUSY), 64'd0);

      // KILL in cycle 10 of a DIV, then MULHSU issued in cycle 11
      seen = 0;
      bus.START = 1'b1; bus.OP = OP_DIV; bus.OPERAND_A = 32'd1000; bus.OPERAND_B = 32'd3;
      bus.RD_ADDR = 5'd9;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.START = 1'b0;
         if (bus.WB_VALID === 1'b1) seen++;
      end
      bus.KILL = 1'b1;
      @(negedge clk);
      if (bus.WB_VALID === 1'b1) seen++;
      check("kill/busy",  64'(bus.BUSY), 64'd0);
      check("kill/no_wb", 64'(seen),     64'd0);
      bus.KILL = 1'b0;
      run_op("kill_mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, MUL_LAT);

      // Asynchronous reset in cycle 20 of a MUL
      bus.START = 1'b1; bus.OP = OP_MUL; bus.OPERAND_A = 32'd123; bus.OPERAND_B = 32'd456;
      bus.RD_ADDR = 5'd7;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) bus.START = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("arst/busy",  64'(bus.BUSY),     64'd0);
      check("arst/valid", 64'(bus.WB_VALID), 64'd0);
      check("arst/addr",  64'(bus.WB_ADDR),  64'd0);
      check("arst/data",  64'(bus.WB_DATA),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.WB_VALID === 1'b1) seen++;
      end
      check("arst/no_stale", 64'(seen), 64'd0);
      run_op("arst/after", OP_MUL, 32'd123, 32'd456, 5'd7, 32'd56088, MUL_LAT);

      // Random operations against the reference model, biased toward corner cases
      for (int i = 0; i < 24; i++) begin
         op  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         rd  = 5'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'h0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = $urandom_range(1, 15);
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, rd, ref_result(op, a, b),
                ref_lat(op, a, b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
